// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer: FSM state encoding, legal WIDTH range
// and the even-parity helper used for the optional parity bit (SER_PARITY_EN).
package ser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHIFT  = 2'b01,
        ST_PARITY = 2'b10
    } ser_state_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic even_parity(input logic [WIDTH_MAX-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the pattern detector: one WIDTH-bit word per
// handshake, one bit per clock, gapless streaming. Define SER_PARITY_EN for a trailing even-parity bit.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("bit_serializer: WIDTH out of range");
    end

    ser_state_e       r_state;
    ser_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_accept;
    logic             w_head_nxt;
    logic             w_bit_nxt;
    logic             w_valid_nxt;
    logic             w_done_nxt;
`ifdef SER_PARITY_EN
    logic             r_par;
    logic             w_par_nxt;
`endif

    assign w_accept = din_valid & din_ready;

    // Ready decode: open in IDLE and in the cycle carrying a word's final line bit.
    always_comb begin
        din_ready = 1'b0;
        if (reset) begin
            din_ready = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE:   din_ready = 1'b1;
`ifdef SER_PARITY_EN
                ST_SHIFT:  din_ready = 1'b0;
                ST_PARITY: din_ready = 1'b1;
`else
                ST_SHIFT:  din_ready = (r_cnt == LAST);
`endif
                default:   din_ready = 1'b0;
            endcase
        end
    end

    // Next-state, shift register and bit counter.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
`ifdef SER_PARITY_EN
        w_par_nxt   = r_par;
`endif
        if (w_accept) begin
            w_state_nxt = ST_SHIFT;
            w_shreg_nxt = din;
            w_cnt_nxt   = {CW{1'b0}};
`ifdef SER_PARITY_EN
            w_par_nxt   = even_parity(WIDTH_MAX'(din));
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_SHIFT: begin
                    if (r_cnt == LAST) begin
`ifdef SER_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_IDLE;
`endif
                    end else begin
                        w_cnt_nxt   = r_cnt + CW'(1);
                        w_shreg_nxt = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                                : {1'b0, r_shreg[WIDTH-1:1]};
                    end
                end
`ifdef SER_PARITY_EN
                ST_PARITY: begin
                    w_state_nxt = ST_IDLE;
                end
`endif
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Output values for the coming cycle, taken from the next-state view so the outputs can be registered.
    always_comb begin
        w_head_nxt  = MSB_FIRST ? w_shreg_nxt[WIDTH-1] : w_shreg_nxt[0];
        w_bit_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        case (w_state_nxt)
            ST_SHIFT: begin
                w_bit_nxt   = w_head_nxt;
                w_valid_nxt = 1'b1;
`ifdef SER_PARITY_EN
                w_done_nxt  = 1'b0;
`else
                w_done_nxt  = (w_cnt_nxt == LAST);
`endif
            end
`ifdef SER_PARITY_EN
            ST_PARITY: begin
                w_bit_nxt   = w_par_nxt;
                w_valid_nxt = 1'b1;
                w_done_nxt  = 1'b1;
            end
`endif
            default: begin
                w_bit_nxt   = 1'b0;
                w_valid_nxt = 1'b0;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any word in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_shreg   <= {WIDTH{1'b0}};
            r_cnt     <= {CW{1'b0}};
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            word_done <= 1'b0;
`ifdef SER_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_cnt     <= w_cnt_nxt;
            bit_out   <= w_bit_nxt;
            bit_valid <= w_valid_nxt;
            busy      <= w_valid_nxt;
            word_done <= w_done_nxt;
`ifdef SER_PARITY_EN
            r_par     <= w_par_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer; parity scenarios run when SER_PARITY_EN is defined.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din_m, din_l;
    logic       vld_m, vld_l;
    logic       rdy_m, bo_m, bv_m, busy_m, wd_m;
    logic       rdy_l, bo_l, bv_l, busy_l, wd_l;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .din(din_m), .din_valid(vld_m), .din_ready(rdy_m),
        .bit_out(bo_m), .bit_valid(bv_m), .busy(busy_m), .word_done(wd_m)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .din(din_l), .din_valid(vld_l), .din_ready(rdy_l),
        .bit_out(bo_l), .bit_valid(bv_l), .busy(busy_l), .word_done(wd_l)
    );

    task automatic test_reset();
        reset = 1'b1; vld_m = 1'b1; din_m = 8'hFF; vld_l = 1'b1; din_l = 8'hFF;
        repeat (3) @(negedge clk);
        checks++; if (bv_m !== 1'b0) begin errors++; $display("FAIL rst_bit_valid got %b want 0", bv_m); end
        checks++; if (bo_m !== 1'b0) begin errors++; $display("FAIL rst_bit_out got %b want 0", bo_m); end
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy_m); end
        checks++; if (wd_m !== 1'b0) begin errors++; $display("FAIL rst_word_done got %b want 0", wd_m); end
        checks++; if (rdy_m !== 1'b0) begin errors++; $display("FAIL rst_din_ready got %b want 0", rdy_m); end
        checks++; if (rdy_l !== 1'b0) begin errors++; $display("FAIL rst_din_ready_lsb got %b want 0", rdy_l); end
        reset = 1'b0; vld_m = 1'b0; vld_l = 1'b0;
        #1;
        checks++; if (rdy_m !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b want 1", rdy_m); end
        @(negedge clk);
        checks++; if (bv_m !== 1'b0 || busy_m !== 1'b0) begin errors++; $display("FAIL post_rst_idle got bv=%b busy=%b want 0 0", bv_m, busy_m); end
    endtask

`ifndef SER_PARITY_EN
    task automatic test_msb_a5();
        logic [7:0] exp_w = 8'hA5;
        logic [2:0] hist = 3'b000;
        logic [8:0] hits = 9'h000;
        @(negedge clk);
        din_m = 8'hA5; vld_m = 1'b1;
        checks++; if (rdy_m !== 1'b1) begin errors++; $display("FAIL a5_ready got %b want 1", rdy_m); end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) begin vld_m = 1'b0; din_m = 8'h00; end
            checks++; if (bo_m !== exp_w[8-i]) begin errors++; $display("FAIL a5_bit%0d got %b want %b", i, bo_m, exp_w[8-i]); end
            checks++; if (bv_m !== 1'b1 || busy_m !== 1'b1) begin errors++; $display("FAIL a5_valid%0d got bv=%b busy=%b want 1 1", i, bv_m, busy_m); end
            checks++; if (wd_m !== (i == 8)) begin errors++; $display("FAIL a5_done%0d got %b want %b", i, wd_m, (i == 8)); end
            checks++; if (rdy_m !== (i == 8)) begin errors++; $display("FAIL a5_ready%0d got %b want %b", i, rdy_m, (i == 8)); end
            hist = {hist[1:0], bo_m};
            if (hist == 3'b101) hits[i] = 1'b1;
        end
        checks++; if (hits !== 9'b1_0000_1000) begin errors++; $display("FAIL a5_detect got %b want 100001000", hits); end
        @(negedge clk);
        checks++; if (bv_m !== 1'b0 || busy_m !== 1'b0 || bo_m !== 1'b0 || wd_m !== 1'b0) begin
            errors++; $display("FAIL a5_after got bv=%b busy=%b bo=%b wd=%b want all 0", bv_m, busy_m, bo_m, wd_m);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_s = 16'h0580;
        logic [2:0]  hist = 3'b000;
        logic [16:0] hits = 17'h0;
        @(negedge clk);
        din_m = 8'h05; vld_m = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 1) din_m = 8'h80;
            checks++; if (bo_m !== exp_s[16-i]) begin errors++; $display("FAIL b2b_bit%0d got %b want %b", i, bo_m, exp_s[16-i]); end
            checks++; if (bv_m !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d got %b want 1", i, bv_m); end
            checks++; if (wd_m !== (i == 8 || i == 16)) begin errors++; $display("FAIL b2b_done%0d got %b want %b", i, wd_m, (i == 8 || i == 16)); end
            checks++; if (rdy_m !== (i == 8 || i == 16)) begin errors++; $display("FAIL b2b_ready%0d got %b want %b", i, rdy_m, (i == 8 || i == 16)); end
            hist = {hist[1:0], bo_m};
            if (hist == 3'b101) hits[i] = 1'b1;
            if (i == 16) vld_m = 1'b0;
        end
        checks++; if (hits !== 17'h00100) begin errors++; $display("FAIL b2b_detect got %h want 00100", hits); end
        @(negedge clk);
        checks++; if (bv_m !== 1'b0) begin errors++; $display("FAIL b2b_after got %b want 0", bv_m); end
    endtask

    task automatic test_lsb_first();
        @(negedge clk);
        din_l = 8'h01; vld_l = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) begin vld_l = 1'b0; din_l = 8'hFE; end
            checks++; if (bo_l !== (i == 1)) begin errors++; $display("FAIL lsb_bit%0d got %b want %b", i, bo_l, (i == 1)); end
            checks++; if (bv_l !== 1'b1 || busy_l !== 1'b1) begin errors++; $display("FAIL lsb_valid%0d got bv=%b busy=%b want 1 1", i, bv_l, busy_l); end
            checks++; if (wd_l !== (i == 8)) begin errors++; $display("FAIL lsb_done%0d got %b want %b", i, wd_l, (i == 8)); end
        end
        @(negedge clk);
        checks++; if (bv_l !== 1'b0 || bo_l !== 1'b0) begin errors++; $display("FAIL lsb_after got bv=%b bo=%b want 0 0", bv_l, bo_l); end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] exp_w = 8'h3C;
        @(negedge clk);
        din_m = 8'hFF; vld_m = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i == 1) vld_m = 1'b0;
            checks++; if (bv_m !== 1'b1 || bo_m !== 1'b1) begin errors++; $display("FAIL mid_pre%0d got bv=%b bo=%b want 1 1", i, bv_m, bo_m); end
        end
        reset = 1'b1; vld_m = 1'b1;
        #1;
        checks++; if (rdy_m !== 1'b0) begin errors++; $display("FAIL mid_ready_in_reset got %b want 0", rdy_m); end
        @(negedge clk);
        checks++; if (bv_m !== 1'b0 || bo_m !== 1'b0 || wd_m !== 1'b0 || busy_m !== 1'b0) begin
            errors++; $display("FAIL mid_abort got bv=%b bo=%b wd=%b busy=%b want all 0", bv_m, bo_m, wd_m, busy_m);
        end
        reset = 1'b0; vld_m = 1'b0;
        for (int i = 5; i <= 10; i++) begin
            @(negedge clk);
            checks++; if (wd_m !== 1'b0 || bv_m !== 1'b0) begin errors++; $display("FAIL mid_quiet%0d got wd=%b bv=%b want 0 0", i, wd_m, bv_m); end
        end
        din_m = 8'h3C; vld_m = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) vld_m = 1'b0;
            checks++; if (bo_m !== exp_w[8-i] || bv_m !== 1'b1) begin errors++; $display("FAIL mid_next_bit%0d got bo=%b bv=%b want %b 1", i, bo_m, bv_m, exp_w[8-i]); end
            checks++; if (wd_m !== (i == 8)) begin errors++; $display("FAIL mid_next_done%0d got %b want %b", i, wd_m, (i == 8)); end
        end
    endtask

    task automatic test_changing_din();
        logic [15:0] rx = 16'h0;
        @(negedge clk);
        checks++; if (bv_m !== 1'b0 || rdy_m !== 1'b1) begin errors++; $display("FAIL chg_start got bv=%b rdy=%b want 0 1", bv_m, rdy_m); end
        for (int k = 0; k <= 16; k++) begin
            if (k >= 1) begin
                @(negedge clk);
                checks++; if (bv_m !== 1'b1) begin errors++; $display("FAIL chg_valid%0d got %b want 1", k, bv_m); end
                rx = {rx[14:0], bo_m};
                checks++; if (rdy_m !== (k == 8 || k == 16)) begin errors++; $display("FAIL chg_ready%0d got %b want %b", k, rdy_m, (k == 8 || k == 16)); end
            end
            din_m = 8'(8'h10 + k);
            vld_m = (k < 16);
        end
        checks++; if (rx !== 16'h1018) begin errors++; $display("FAIL chg_stream got %h want 1018", rx); end
        @(negedge clk);
        checks++; if (bv_m !== 1'b0) begin errors++; $display("FAIL chg_after got %b want 0", bv_m); end
    endtask
`else
    task automatic test_parity(input logic [7:0] word, input logic par);
        @(negedge clk);
        din_m = word; vld_m = 1'b1;
        checks++; if (rdy_m !== 1'b1) begin errors++; $display("FAIL par_ready_%h got %b want 1", word, rdy_m); end
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 1) begin vld_m = 1'b0; din_m = ~word; end
            if (i <= 8) begin
                checks++; if (bo_m !== word[8-i]) begin errors++; $display("FAIL par_%h_bit%0d got %b want %b", word, i, bo_m, word[8-i]); end
            end else begin
                checks++; if (bo_m !== par) begin errors++; $display("FAIL par_%h_parity got %b want %b", word, bo_m, par); end
            end
            checks++; if (bv_m !== 1'b1 || busy_m !== 1'b1) begin errors++; $display("FAIL par_%h_valid%0d got bv=%b busy=%b want 1 1", word, i, bv_m, busy_m); end
            checks++; if (wd_m !== (i == 9)) begin errors++; $display("FAIL par_%h_done%0d got %b want %b", word, i, wd_m, (i == 9)); end
            checks++; if (rdy_m !== (i == 9)) begin errors++; $display("FAIL par_%h_ready%0d got %b want %b", word, i, rdy_m, (i == 9)); end
        end
        @(negedge clk);
        checks++; if (bv_m !== 1'b0 || bo_m !== 1'b0) begin errors++; $display("FAIL par_%h_after got bv=%b bo=%b want 0 0", word, bv_m, bo_m); end
    endtask
`endif

    initial begin
        reset = 1'b1; din_m = 8'h00; vld_m = 1'b0; din_l = 8'h00; vld_l = 1'b0;
        test_reset();
`ifndef SER_PARITY_EN
        test_msb_a5();
        test_back_to_back();
        test_lsb_first();
        test_reset_mid_word();
        test_changing_din();
`else
        test_parity(8'hA5, 1'b0);
        test_parity(8'h07, 1'b1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached, got no completion want completion before 100000");
        $fatal(1);
    end

endmodule
